// File: rtl/data_sram_responder_if.sv
// Data SRAM port between the CPU core (master) and the responder (slave).
//   we    : full-word write strobe
//   addr  : byte address, bits [1:0] ignored by the responder
//   wdata : write data
//   rdata : registered read data, one cycle after the address
interface data_sram_responder_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, output addr, output wdata, input rdata);
    modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_responder.sv
// Target-side responder for the core's data SRAM port. Every cycle the
// presented address is decoded to the RAM window, the MMIO register page or
// unmapped space; read data is returned one cycle later.
//   clk       : system clock
//   resetn    : asynchronous active-low reset
//   data_sram : core data port (slave side)
//   switch    : board switches, asynchronous to clk
//   led       : LED register value
//   bus_err   : sticky flag, set by any unmapped access, RW1C at 0xE104
module data_sram_responder #(
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] RAM_BASE  = 32'h1c00_0000,
    parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000
) (
    input  logic                  clk,
    input  logic                  resetn,
    data_sram_responder_if.slave  data_sram,
    input  logic [7:0]            switch,
    output logic [15:0]           led,
    output logic                  bus_err
);

    localparam logic [15:0] OFF_LED     = 16'hF000;
    localparam logic [15:0] OFF_SWITCH  = 16'hF004;
    localparam logic [15:0] OFF_TIMER   = 16'hE000;
    localparam logic [15:0] OFF_WRCOUNT = 16'hE100;
    localparam logic [15:0] OFF_ERR     = 16'hE104;

    logic [31:0] ram_q [0:(1<<RAM_AW)-1];
    logic [31:0] ram_rd_q;

    logic [15:0] led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] wr_count_q, wr_count_d;
    logic        bus_err_q, bus_err_d;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic        sel_ram_q, sel_ram_d;
    logic [31:0] reg_rd_q, reg_rd_d;

    logic              ram_sel, mmio_sel, unmapped;
    logic [RAM_AW-1:0] ram_idx;
    logic [15:0]       off;
    logic              unused_addr_bits;

    // RAM takes priority should the two windows ever be configured to overlap.
    always_comb begin
        ram_sel  = (data_sram.addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);
        mmio_sel = (data_sram.addr[31:16] == MMIO_BASE[31:16]) && !ram_sel;
        unmapped = !ram_sel && !mmio_sel;
        ram_idx  = data_sram.addr[RAM_AW+1:2];
        off      = {data_sram.addr[15:2], 2'b00};
    end

    assign unused_addr_bits = &{1'b0, data_sram.addr[1:0]};

    always_comb begin
        led_d      = led_q;
        timer_d    = timer_q + 32'd1;
        wr_count_d = wr_count_q;
        bus_err_d  = bus_err_q;
        reg_rd_d   = 32'h0;
        sel_ram_d  = ram_sel;

        if (mmio_sel) begin
            case (off)
                OFF_LED: begin
                    reg_rd_d = {16'h0, led_q};
                    if (data_sram.we) led_d = data_sram.wdata[15:0];
                end
                OFF_SWITCH:  reg_rd_d = {24'h0, sw_sync_q};
                OFF_TIMER: begin
                    reg_rd_d = timer_q;
                    if (data_sram.we) timer_d = data_sram.wdata;
                end
                OFF_WRCOUNT: reg_rd_d = wr_count_q;
                OFF_ERR: begin
                    reg_rd_d = {31'h0, bus_err_q};
                    if (data_sram.we && data_sram.wdata[0]) bus_err_d = 1'b0;
                end
                default: reg_rd_d = 32'h0;
            endcase
        end

        if (ram_sel && data_sram.we) wr_count_d = wr_count_q + 32'd1;

        // Set after clear so a coincident unmapped access wins.
        if (unmapped) bus_err_d = 1'b1;
    end

    // RAM array carries no reset; read-first on a same-word write.
    always_ff @(posedge clk) begin
        if (ram_sel && data_sram.we) ram_q[ram_idx] <= data_sram.wdata;
        ram_rd_q <= ram_q[ram_idx];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q      <= 16'h0;
            timer_q    <= 32'h0;
            wr_count_q <= 32'h0;
            bus_err_q  <= 1'b0;
            sw_meta_q  <= 8'h0;
            sw_sync_q  <= 8'h0;
            sel_ram_q  <= 1'b0;
            reg_rd_q   <= 32'h0;
        end else begin
            led_q      <= led_d;
            timer_q    <= timer_d;
            wr_count_q <= wr_count_d;
            bus_err_q  <= bus_err_d;
            sw_meta_q  <= switch;
            sw_sync_q  <= sw_meta_q;
            sel_ram_q  <= sel_ram_d;
            reg_rd_q   <= reg_rd_d;
        end
    end

    // sel_ram_q clears on reset, so rdata drops to 0 without touching the RAM.
    assign data_sram.rdata = sel_ram_q ? ram_rd_q : reg_rd_q;
    assign led             = led_q;
    assign bus_err         = bus_err_q;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

    localparam logic [31:0] RAM_BASE = 32'h1c00_0000;
    localparam logic [31:0] RAM_SIZE = 32'h0000_4000;

    logic        clk;
    logic        resetn;
    logic [7:0]  switch;
    logic [15:0] led;
    logic        bus_err;

    data_sram_responder_if bus ();

    data_sram_responder dut (
        .clk       (clk),
        .resetn    (resetn),
        .data_sram (bus),
        .switch    (switch),
        .led       (led),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_ram [int unsigned];
    logic [15:0] m_led;
    logic [31:0] m_timer;
    logic [31:0] m_wrcnt;
    logic        m_err;
    logic [7:0]  m_sw_first;
    logic [7:0]  m_sw_second;

    function automatic void model_reset();
        m_led = 16'h0; m_timer = 32'h0; m_wrcnt = 32'h0; m_err = 1'b0;
        m_sw_first = 8'h0; m_sw_second = 8'h0;
    endfunction

    // One bus cycle: presents the access, computes the expected read value
    // from the model's pre-edge state, advances the model at the edge, and
    // returns 1 time unit after the edge.
    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] exp);
        bit          is_ram, is_mmio;
        int unsigned idx;
        logic [31:0] off;
        logic [31:0] next_timer;
        bus.we = we; bus.addr = addr; bus.wdata = wdata;
        is_ram  = (addr >= RAM_BASE) && (addr < RAM_BASE + RAM_SIZE);
        is_mmio = !is_ram && ((addr >> 16) == 32'h0000_bfaf);
        idx     = (addr - RAM_BASE) >> 2;
        off     = addr & 32'h0000_fffc;
        exp     = 32'h0;
        next_timer = m_timer + 32'd1;
        if (is_ram) begin
            exp = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
        end else if (is_mmio) begin
            if (off == 32'hf000) exp = {16'h0, m_led};
            else if (off == 32'hf004) exp = {24'h0, m_sw_second};
            else if (off == 32'he000) exp = m_timer;
            else if (off == 32'he100) exp = m_wrcnt;
            else if (off == 32'he104) exp = {31'h0, m_err};
        end
        @(posedge clk);
        m_sw_second = m_sw_first;
        m_sw_first  = switch;
        if (is_ram && we) begin
            m_ram[idx] = wdata;
            m_wrcnt = m_wrcnt + 32'd1;
        end
        if (is_mmio && we) begin
            if (off == 32'hf000) m_led = wdata[15:0];
            if (off == 32'he000) next_timer = wdata;
            if (off == 32'he104 && wdata[0]) m_err = 1'b0;
        end
        if (!is_ram && !is_mmio) m_err = 1'b1;
        m_timer = next_timer;
        #1;
    endtask

    task automatic idle();
        logic [31:0] e;
        do_access(1'b0, 32'hbfaf_0010, 32'h0, e);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want %h", bus.rdata, 32'h0); end
        checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h want %h", led, 16'h0); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
        do_access(1'b0, 32'hbfaf_e000, 32'h0, e);
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_timer: got %h want %h", bus.rdata, 32'h0); end
        do_access(1'b0, 32'hbfaf_e100, 32'h0, e);
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_wrcount: got %h want %h", bus.rdata, 32'h0); end
    endtask

    task automatic test_ram_rw();
        logic [31:0] e;
        do_access(1'b1, 32'h1c00_0010, 32'hdead_beef, e);
        do_access(1'b0, 32'h1c00_0010, 32'h0, e);
        checks++; if (bus.rdata !== 32'hdead_beef) begin errors++; $display("FAIL ram_read: got %h want %h", bus.rdata, 32'hdead_beef); end
        do_access(1'b0, 32'hbfaf_e100, 32'h0, e);
        checks++; if (bus.rdata !== 32'h1) begin errors++; $display("FAIL wrcount_one: got %h want %h", bus.rdata, 32'h1); end
    endtask

    task automatic test_read_first();
        logic [31:0] e;
        do_access(1'b1, 32'h1c00_0020, 32'h5, e);
        do_access(1'b1, 32'h1c00_0020, 32'h1, e);
        checks++; if (bus.rdata !== 32'h5) begin errors++; $display("FAIL read_first_old: got %h want %h", bus.rdata, 32'h5); end
        do_access(1'b0, 32'h1c00_0023, 32'h0, e);
        checks++; if (bus.rdata !== 32'h1) begin errors++; $display("FAIL read_first_new: got %h want %h", bus.rdata, 32'h1); end
    endtask

    task automatic test_led();
        logic [31:0] e;
        do_access(1'b1, 32'hbfaf_f000, 32'h0001_abcd, e);
        checks++; if (led !== 16'habcd) begin errors++; $display("FAIL led_port: got %h want %h", led, 16'habcd); end
        do_access(1'b0, 32'hbfaf_f000, 32'h0, e);
        checks++; if (bus.rdata !== 32'h0000_abcd) begin errors++; $display("FAIL led_read: got %h want %h", bus.rdata, 32'h0000_abcd); end
    endtask

    task automatic test_switch();
        logic [31:0] e;
        switch = 8'h5a;
        idle();
        do_access(1'b0, 32'hbfaf_f004, 32'h0, e);
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL switch_early: got %h want %h", bus.rdata, 32'h0); end
        idle();
        do_access(1'b0, 32'hbfaf_f004, 32'h0, e);
        checks++; if (bus.rdata !== 32'h5a) begin errors++; $display("FAIL switch_read: got %h want %h", bus.rdata, 32'h5a); end
    endtask

    task automatic test_timer_wrap();
        logic [31:0] e;
        logic [31:0] want [3];
        want[0] = 32'hffff_ffff; want[1] = 32'h0; want[2] = 32'h1;
        do_access(1'b1, 32'hbfaf_e000, 32'hffff_fffe, e);
        idle();
        for (int i = 0; i < 3; i++) begin
            do_access(1'b0, 32'hbfaf_e000, 32'h0, e);
            checks++; if (bus.rdata !== want[i]) begin errors++; $display("FAIL timer_wrap_%0d: got %h want %h", i, bus.rdata, want[i]); end
        end
    endtask

    task automatic test_bus_err();
        logic [31:0] e;
        do_access(1'b0, 32'h8000_0000, 32'h0, e);
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL unmapped_rdata: got %h want %h", bus.rdata, 32'h0); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_set: got %b want 1", bus_err); end
        do_access(1'b0, 32'hbfaf_e104, 32'h0, e);
        checks++; if (bus.rdata !== 32'h1) begin errors++; $display("FAIL err_read: got %h want %h", bus.rdata, 32'h1); end
        do_access(1'b1, 32'hbfaf_e104, 32'h1, e);
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL bus_err_clear: got %b want 0", bus_err); end
        do_access(1'b1, RAM_BASE + RAM_SIZE, 32'h1234, e);
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL ram_end_unmapped: got %b want 1", bus_err); end
        do_access(1'b1, 32'hbfaf_e104, 32'h1, e);
    endtask

    task automatic test_random();
        logic [31:0] e, addr, wdata;
        logic        we;
        int unsigned idxs [6];
        logic [31:0] offs [7];
        idxs[0] = 0; idxs[1] = 1; idxs[2] = 4; idxs[3] = 8; idxs[4] = 2047; idxs[5] = 4095;
        offs[0] = 32'hf000; offs[1] = 32'hf004; offs[2] = 32'he000; offs[3] = 32'he100;
        offs[4] = 32'he104; offs[5] = 32'h0010; offs[6] = 32'hf008;
        for (int i = 0; i < 6; i++) do_access(1'b1, RAM_BASE + idxs[i] * 4, $urandom, e);
        for (int n = 0; n < 300; n++) begin
            int kind;
            kind  = $urandom_range(0, 9);
            we    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            if (kind <= 4) addr = RAM_BASE + idxs[$urandom_range(0, 5)] * 4 + $urandom_range(0, 3);
            else if (kind <= 8) addr = 32'hbfaf_0000 | offs[$urandom_range(0, 6)] | $urandom_range(0, 3);
            else addr = ($urandom_range(0, 1) != 0) ? RAM_BASE - 4 : $urandom & 32'h7fff_fffc;
            if ($urandom_range(0, 7) == 0) switch = 8'($urandom);
            do_access(we, addr, wdata, e);
            checks++; if (bus.rdata !== e) begin errors++; $display("FAIL rand_rdata[%0d] addr %h: got %h want %h", n, addr, bus.rdata, e); end
            checks++; if (led !== m_led) begin errors++; $display("FAIL rand_led[%0d]: got %h want %h", n, led, m_led); end
            checks++; if (bus_err !== m_err) begin errors++; $display("FAIL rand_bus_err[%0d]: got %b want %b", n, bus_err, m_err); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        do_access(1'b1, 32'hbfaf_f000, 32'h0000_1234, e);
        do_access(1'b1, 32'h1c00_0040, 32'h77, e);
        do_access(1'b0, 32'h9000_0000, 32'h0, e);
        do_access(1'b0, 32'hbfaf_e104, 32'h0, e);
        bus.we = 1'b1; bus.addr = 32'hbfaf_f000; bus.wdata = 32'hffff;
        #3 resetn = 1'b0;
        #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL midreset_rdata: got %h want %h", bus.rdata, 32'h0); end
        checks++; if (led !== 16'h0) begin errors++; $display("FAIL midreset_led: got %h want %h", led, 16'h0); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL midreset_bus_err: got %b want 0", bus_err); end
        @(posedge clk);
        #1;
        checks++; if (led !== 16'h0) begin errors++; $display("FAIL midreset_no_commit: got %h want %h", led, 16'h0); end
        bus.we = 1'b0;
        resetn = 1'b1;
        model_reset();
        do_access(1'b0, 32'hbfaf_e000, 32'h0, e);
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL midreset_timer: got %h want %h", bus.rdata, 32'h0); end
        do_access(1'b0, 32'hbfaf_e100, 32'h0, e);
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL midreset_wrcount: got %h want %h", bus.rdata, 32'h0); end
        do_access(1'b0, 32'h1c00_0040, 32'h0, e);
        checks++; if (bus.rdata !== 32'h77) begin errors++; $display("FAIL ram_survives_reset: got %h want %h", bus.rdata, 32'h77); end
    endtask

    initial begin
        resetn = 1'b0;
        switch = 8'h0;
        bus.we = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        test_reset();
        test_ram_rw();
        test_read_first();
        test_led();
        test_switch();
        test_timer_wrap();
        test_bus_err();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
